// File: rtl/fifo_rd_pkg.sv
// Shared types and widths for the FIFO read-side framer.
package fifo_rd_pkg;

  localparam int unsigned DEF_D_WIDTH = 32;
  localparam int unsigned DEF_CNT_W   = 32;
  localparam int unsigned BUF_DEPTH   = 2;
  localparam int unsigned OCC_W       = 2;
  localparam int unsigned IDX_W       = 16;
  localparam int unsigned FRAME_CNT_W = 16;

  // One buffered stream word with its frame-end flag.
  typedef struct packed {
    logic [DEF_D_WIDTH-1:0] data;
    logic                   last;
  } rd_entry_t;

endpackage

// File: rtl/fifo_rd_framer_if.sv
// FIFO read port plus outgoing valid/ready stream, seen from the framer (master).
interface fifo_rd_framer_if
  import fifo_rd_pkg::*;
#(
  parameter int unsigned D_WIDTH = DEF_D_WIDTH
);

  logic               fifo_empty;
  logic [D_WIDTH-1:0] fifo_data;
  logic               fifo_rd;
  logic               m_valid;
  logic               m_ready;
  logic [D_WIDTH-1:0] m_data;
  logic               m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_rd_framer_stream_buf2.sv
// Two-entry register FIFO; head entry and valid come straight from flops.
module stream_buf2
  import fifo_rd_pkg::*;
#(
  parameter int unsigned E_W = $bits(rd_entry_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [E_W-1:0]   in_entry,
  output logic             out_valid,
  output logic [E_W-1:0]   out_entry,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occ
);

  logic [E_W-1:0]   slot0_q, slot0_d;
  logic [E_W-1:0]   slot1_q, slot1_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             valid_q;
  logic             push;
  logic             take;

  // Next-state: slot0 is always the head, slot1 the second entry.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    push    = in_valid & (occ_q != OCC_W'(BUF_DEPTH));
    take    = valid_q & out_ready;
    case ({push, take})
      2'b10: begin
        if (occ_q == OCC_W'(0)) slot0_d = in_entry;
        else                    slot1_d = in_entry;
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == OCC_W'(1)) begin
          slot0_d = in_entry;
        end else begin
          slot0_d = slot1_q;
          slot1_d = in_entry;
        end
      end
      default: ;
    endcase
  end

  // State registers; valid is precomputed so out_valid is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
      valid_q <= (occ_d != OCC_W'(0));
    end
  end

  assign out_valid = valid_q;
  assign out_entry = slot0_q;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_framer.sv
// Pops a FWFT FIFO into a 2-deep buffer and emits a framed valid/ready stream.
module fifo_rd_framer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned D_WIDTH   = DEF_D_WIDTH,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                   r_clk,
  input  logic                   r_rst_n,
  input  logic                   en,
  fifo_rd_framer_if.master       bus,
  output logic [CNT_W-1:0]       word_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned     E_W      = D_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic                   pop_c;
  logic                   pop_last;
  logic                   xfer;
  logic [OCC_W-1:0]       occ;
  logic                   buf_valid;
  logic [E_W-1:0]         in_entry;
  logic [E_W-1:0]         buf_entry;
  logic [IDX_W-1:0]       pop_idx_q, pop_idx_d;
  logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Pop whenever there is room; never waits on m_ready, and is held off in reset.
  assign pop_c       = r_rst_n & en & ~bus.fifo_empty & (occ != OCC_W'(BUF_DEPTH));
  assign bus.fifo_rd = pop_c;
  assign pop_last    = (pop_idx_q == LAST_IDX);
  assign in_entry    = {bus.fifo_data, pop_last};

  stream_buf2 #(.E_W(E_W)) u_buf (
    .clk       (r_clk),
    .rst_n     (r_rst_n),
    .in_valid  (pop_c),
    .in_entry  (in_entry),
    .out_valid (buf_valid),
    .out_entry (buf_entry),
    .out_ready (bus.m_ready),
    .occ       (occ)
  );

  assign bus.m_valid = buf_valid;
  assign bus.m_data  = buf_entry[E_W-1:1];
  assign bus.m_last  = buf_entry[0];
  assign xfer        = buf_valid & bus.m_ready;

  // Frame index advances per pop; counters advance per downstream transfer.
  always_comb begin
    pop_idx_d   = pop_idx_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (pop_c) begin
      pop_idx_d = pop_last ? '0 : pop_idx_q + IDX_W'(1);
    end
    if (xfer) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (bus.m_last) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  // Frame index and status counter registers.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      pop_idx_q   <= '0;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      pop_idx_q   <= pop_idx_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign word_cnt  = word_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Bench for fifo_rd_framer: the FIFO is a queue, the expected stream a second queue.
module tb_fifo_rd_framer;
  import fifo_rd_pkg::*;

  localparam int unsigned FL = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  logic          r_clk = 1'b0;
  logic          r_rst_n;
  logic          en;
  logic [CW-1:0] word_cnt;
  logic [15:0]   frame_cnt;

  fifo_rd_framer_if #(.D_WIDTH(DW)) bus ();

  fifo_rd_framer #(.D_WIDTH(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .r_clk     (r_clk),
    .r_rst_n   (r_rst_n),
    .en        (en),
    .bus       (bus),
    .word_cnt  (word_cnt),
    .frame_cnt (frame_cnt)
  );

  always #15 r_clk = ~r_clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } exp_t;

  typedef struct {
    bit rst;
    int push_n;
    bit rnd_data;
    bit en;
    int ready_mode;
    int cycles;
    int exp_wc;
    int exp_fc;
    int exp_left;
  } row_t;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  int unsigned   pops, m_wc, m_fc;
  int unsigned   vectors, miscompares;
  int            ready_mode;
  row_t          rows[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_inputs();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    case (ready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One r_clk cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit   exp_rd;
    bit   do_xfer;
    exp_t e;
    #1;
    exp_rd = (en == 1'b1) && (fifo_q.size() != 0) && (exp_q.size() < 2);
    chk("fifo_rd", 64'(bus.fifo_rd), 64'(exp_rd));
    chk("m_valid", 64'(bus.m_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("m_data", 64'(bus.m_data), 64'(exp_q[0].data));
      chk("m_last", 64'(bus.m_last), 64'(exp_q[0].last));
    end
    chk("word_cnt", 64'(word_cnt), 64'(CW'(m_wc)));
    chk("frame_cnt", 64'(frame_cnt), 64'(16'(m_fc)));
    do_xfer = (exp_q.size() != 0) && (bus.m_ready == 1'b1);
    @(posedge r_clk);
    if (do_xfer) begin
      if (exp_q[0].last) m_fc++;
      m_wc++;
      void'(exp_q.pop_front());
    end
    if (exp_rd) begin
      e.data = fifo_q.pop_front();
      e.last = ((pops % FL) == FL - 1);
      pops++;
      exp_q.push_back(e);
    end
    @(negedge r_clk);
    drive_inputs();
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    pops = 0;
    m_wc = 0;
    m_fc = 0;
  endtask

  task automatic do_reset();
    r_rst_n = 1'b0;
    clear_model();
    drive_inputs();
    repeat (2) @(negedge r_clk);
    r_rst_n = 1'b1;
    drive_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned w0;
    int          guard;
    vectors     = 0;
    miscompares = 0;
    ready_mode  = 1;
    en          = 1'b1;
    r_rst_n     = 1'b0;
    clear_model();
    fifo_q.push_back(32'hA5A5_0001);
    drive_inputs();

    // Reset state, with the FIFO showing a word so the pop gating is exercised.
    repeat (4) @(negedge r_clk);
    #1;
    chk("rst fifo_rd", 64'(bus.fifo_rd), 64'(0));
    chk("rst m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst m_data", 64'(bus.m_data), 64'(0));
    chk("rst m_last", 64'(bus.m_last), 64'(0));
    chk("rst word_cnt", 64'(word_cnt), 64'(0));
    chk("rst frame_cnt", 64'(frame_cnt), 64'(0));
    @(negedge r_clk);

    //         rst push rnd en rdy cyc  wc  fc left
    rows[0] = '{1, 20,  0, 1, 1,  40, 20,  2, 0};
    rows[1] = '{1, 5,   0, 1, 0,  10,  0,  0, 3};
    rows[2] = '{0, 0,   0, 1, 1,  20,  5,  0, 0};
    rows[3] = '{1, 100, 1, 1, 2, 600, 100, 12, 0};
    rows[4] = '{1, 0,   0, 1, 1,  50,  0,  0, 0};

    foreach (rows[r]) begin
      if (rows[r].rst) do_reset();
      for (int k = 0; k < rows[r].push_n; k++)
        fifo_q.push_back(rows[r].rnd_data ? DW'($urandom) : DW'(k + 1));
      en         = rows[r].en;
      ready_mode = rows[r].ready_mode;
      drive_inputs();
      repeat (rows[r].cycles) tick();
      chk($sformatf("row%0d word_cnt", r), 64'(word_cnt), 64'(rows[r].exp_wc));
      chk($sformatf("row%0d frame_cnt", r), 64'(frame_cnt), 64'(rows[r].exp_fc));
      chk($sformatf("row%0d fifo_left", r), 64'(fifo_q.size()), 64'(rows[r].exp_left));
    end

    // Enable dropped after three pops with six words still queued.
    do_reset();
    for (int k = 0; k < 9; k++) fifo_q.push_back(DW'(100 + k));
    en         = 1'b1;
    ready_mode = 1;
    drive_inputs();
    guard = 0;
    while (pops < 3 && guard < 50) begin
      tick();
      guard++;
    end
    chk("en_gate pops", 64'(pops), 64'(3));
    en = 1'b0;
    drive_inputs();
    w0 = word_cnt;
    repeat (10) tick();
    chk("en_gate drain<=2", 64'((word_cnt >= w0) && (word_cnt <= w0 + 2)), 64'(1));
    chk("en_gate fifo held", 64'(fifo_q.size()), 64'(6));
    en = 1'b1;
    drive_inputs();
    repeat (30) tick();
    chk("en_gate word_cnt", 64'(word_cnt), 64'(9));
    chk("en_gate frame_cnt", 64'(frame_cnt), 64'(1));

    // Asynchronous reset five words into a frame, then a fresh frame.
    do_reset();
    for (int k = 0; k < 13; k++) fifo_q.push_back(DW'(200 + k));
    ready_mode = 1;
    drive_inputs();
    guard = 0;
    while (m_wc < 5 && guard < 50) begin
      tick();
      guard++;
    end
    chk("rst_mid wc before", 64'(word_cnt), 64'(5));
    #2;
    r_rst_n = 1'b0;
    #1;
    chk("rst_mid m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_mid fifo_rd", 64'(bus.fifo_rd), 64'(0));
    chk("rst_mid word_cnt", 64'(word_cnt), 64'(0));
    chk("rst_mid frame_cnt", 64'(frame_cnt), 64'(0));
    clear_model();
    drive_inputs();
    @(negedge r_clk);
    @(negedge r_clk);
    r_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) fifo_q.push_back(DW'(300 + k));
    drive_inputs();
    repeat (20) tick();
    chk("rst_mid new wc", 64'(word_cnt), 64'(8));
    chk("rst_mid new fc", 64'(frame_cnt), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_framer.md
Name: fifo_rd_framer

Overview:
- Read-domain consumer of the async FIFO. It pops words from the FIFO's first-word-fall-through read port (r_data valid whenever r_empty=0; r_inc pops).
- It re-presents the words as a valid/ready stream with a frame-end marker every FRAME_LEN words.
- A 2-entry output buffer decouples downstream backpressure from the FIFO pop path.
- It also keeps running word and frame counters for status.

Parameters:
- D_WIDTH, 32, data width; must match FIFO D_WIDTH.
- FRAME_LEN, 8, words per frame; legal range 1..65535.
- CNT_W, 32, width of the word counter.

Ports:
- r_clk  in  1  read-domain clock, the same clock as the FIFO r_clk.
- r_rst_n  in  1  reset, asynchronous assert, active-low; shared with the FIFO r_rst_n.
- en  in  1  pop enable; when 0, no new FIFO pops, but buffered words still drain.
- fifo_empty  in  1  from FIFO r_empty.
- fifo_data  in  D_WIDTH  from FIFO r_data.
- fifo_rd  out  1  to FIFO r_inc.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream ready.
- m_data  out  D_WIDTH  stream word.
- m_last  out  1  marks the last word of a frame; qualified by m_valid.
- word_cnt  out  CNT_W  count of words accepted downstream (m_valid & m_ready).
- frame_cnt  out  16  count of frames completed downstream.

Behaviour:
- Reset (async, r_rst_n=0):
  - Buffer occupancy = 0; m_valid=0; m_data=0; m_last=0.
  - fifo_rd=0; pop-side frame index=0; word_cnt=0; frame_cnt=0.
  - Reset mid-frame discards buffered words and restarts framing at index 0, consistent with the FIFO being reset by the same signal.
- Pop rule (combinational):
  - fifo_rd = en & ~fifo_empty & (occ < 2).
  - A pop is never gated by m_ready, which keeps fifo_rd free of downstream combinational paths.
- Capture on a pop:
  - The entry {fifo_data, last} is written into the buffer tail on the same r_clk edge.
  - last = (pop_idx == FRAME_LEN-1).
  - pop_idx increments on each pop and wraps to 0 after FRAME_LEN-1.
  - With FRAME_LEN=1, every word has last=1.
- Output side:
  - m_valid = (occ != 0); m_data and m_last come from the buffer head.
  - Outputs are driven from registers only.
  - Latency: a word popped at edge N is visible on m_data after edge N (one cycle from fifo_rd high).
- Handshake:
  - A transfer occurs when m_valid & m_ready at a rising edge.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer.
- Occupancy update per edge:
  - Pop only: occ+1.
  - Transfer only: occ-1; the head advances.
  - Both at once: occ unchanged; the head advances and the new word goes to the tail.
  - occ stays in the range 0..2; occ=2 blocks pops.
- Throughput:
  - With m_ready held at 1 and the FIFO non-empty, one word per cycle is sustained.
  - After a stall with occ=2, the first transfer cycle does not pop; the next cycle resumes one-per-cycle.
- Counters:
  - word_cnt increments per transfer and wraps modulo 2^CNT_W.
  - frame_cnt increments on a transfer with m_last=1 and wraps at 2^16.
- en deasserted mid-frame: pop_idx holds, so framing resumes mid-frame when en returns; already-buffered words drain normally.
- fifo_empty rising in the same cycle as a pop is irrelevant; the rule is evaluated per cycle.
- No pop ever occurs while fifo_empty=1 (no underflow), whatever the state of en or occ.

Decomposition:
- Package fifo_rd_pkg:
  - Localparam BUF_DEPTH=2.
  - typedef struct packed {logic [D_WIDTH-1:0] data; logic last;} rd_entry_t; D_WIDTH comes from the package default of 32.
  - Counter width localparams.
- One sub-module, stream_buf2:
  - A 2-entry register FIFO with in_valid/in_entry, out_valid/out_entry/out_ready and occ[1:0].
  - Same clock and async active-low reset.
- The top level holds the pop logic, the frame index and the counters.

Test Plan:
- Basic transfer:
  - Stimulus: reset 100 ns, then write 20 words 1..20 into the FIFO (w_clk 100 MHz, r_clk 33 MHz), en=1, m_ready=1.
  - Required: m_data sequence 1..20 in order, with no duplicates or gaps.
  - Required: m_last=1 exactly on words 8 and 16; word_cnt=20; frame_cnt=2.
- Backpressure:
  - Stimulus: m_ready=0 for 10 cycles while the FIFO holds 5 words.
  - Required: occ reaches 2 and fifo_rd then stays 0; m_data holds word 1 stable.
  - Required: after m_ready=1, words 1..5 arrive in order and the FIFO ends empty.
- Random ready:
  - Stimulus: m_ready toggles pseudo-randomly over 100 words.
  - Required: output equals input order; word_cnt=100; frame_cnt=12.
  - Required: m_last lands on words 8, 16, …, 96.
- Enable gating:
  - Stimulus: en=0 after 3 pops; 6 words are queued in the FIFO.
  - Required: at most 2 buffered words drain, and fifo_rd stays 0.
  - Required: after en=1, words resume with the next word flagged last at index 8.
- Reset mid-frame:
  - Stimulus: assert r_rst_n=0 asynchronously after 5 words of a frame.
  - Required: m_valid, fifo_rd and the counters are 0 immediately.
  - Required: after release with 8 new words, m_last falls on the 8th new word.
- Empty guard:
  - Stimulus: run with the FIFO empty for 50 cycles, en=1.
  - Required: fifo_rd=0 and m_valid=0 throughout.
